// File: rtl/alarm_buzzer_driver_if.sv
// -----------------------------------------------------------------------------
// alarm_buzzer_driver_if
//
// Purpose: groups the control and drive signals of the alarm buzzer driver so
// the timekeeping logic (master) and the driver (slave) share one bundle.
//
// Signals:
//   trigger      master -> slave  one-cycle alarm-start pulse
//   stop         master -> slave  one-cycle silence request
//   buzzer       slave  -> master registered square-wave piezo drive
//   active       slave  -> master registered, high while a sequence runs
//   burst_count  slave  -> master registered count of completed bursts
//
// Handshake: there is no valid/ready pair. trigger and stop are qualifiers
// that act on the single rising edge where they are high; the slave never
// back-pressures, and a pulse that arrives when it has no meaning (trigger
// while running, stop while idle) is dropped rather than held.
// -----------------------------------------------------------------------------
interface alarm_buzzer_driver_if;
    logic       trigger;
    logic       stop;
    logic       buzzer;
    logic       active;
    logic [7:0] burst_count;

    modport master (
        output trigger,
        output stop,
        input  buzzer,
        input  active,
        input  burst_count
    );

    modport slave (
        input  trigger,
        input  stop,
        output buzzer,
        output active,
        output burst_count
    );
endinterface

// File: rtl/alarm_buzzer_driver.sv
// -----------------------------------------------------------------------------
// alarm_buzzer_driver
//
// Purpose: drives a piezo with bursts of beeps once an alarm is triggered.
// A burst is BEEPS beeps of BEEP_ON cycles each (a square wave of half-period
// TONE_HALF), separated by BEEP_OFF cycles of silence, followed by GAP cycles
// of silence. Bursts repeat until stop, reset, or MAX_BURSTS bursts have
// completed (MAX_BURSTS = 0 repeats forever).
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous active-low reset
//   bus          alarm_buzzer_driver_if.slave (trigger, stop in;
//                buzzer, active, burst_count out)
//   dbg_state_o  current FSM state (0 IDLE, 1 BEEP_ON, 2 BEEP_OFF, 3 GAP)
// -----------------------------------------------------------------------------
module alarm_buzzer_driver #(
    parameter int unsigned TONE_HALF  = 2500,
    parameter int unsigned BEEP_ON    = 5_000_000,
    parameter int unsigned BEEP_OFF   = 5_000_000,
    parameter int unsigned BEEPS      = 4,
    parameter int unsigned GAP        = 50_000_000,
    parameter int unsigned MAX_BURSTS = 60
) (
    input  logic                        clk,
    input  logic                        rst_n,
    alarm_buzzer_driver_if.slave        bus,
    output logic [1:0]                  dbg_state_o
);

    // Each phase timer counts 0 .. P-1, so $clog2(P) bits are enough; a
    // parameter of 1 still needs a one-bit register.
    localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int ON_W   = (BEEP_ON   > 1) ? $clog2(BEEP_ON)   : 1;
    localparam int OFF_W  = (BEEP_OFF  > 1) ? $clog2(BEEP_OFF)  : 1;
    localparam int GAP_W  = (GAP       > 1) ? $clog2(GAP)       : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(BEEP_ON - 1);
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(BEEP_OFF - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [7:0]        BEEP_LAST = 8'(BEEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BEEP_ON  = 2'd1,
        S_BEEP_OFF = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t              state_q;
    logic                buzzer_q;
    logic                active_q;
    logic [7:0]          burst_cnt_q;
    logic [7:0]          beep_idx_q;
    logic [TONE_W-1:0]   tone_cnt_q;
    logic [ON_W-1:0]     on_cnt_q;
    logic [OFF_W-1:0]    off_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;

    // Burst count as it will be once the current GAP ends (saturating).
    logic [7:0]          burst_cnt_d;
    // High when that incremented count ends the alarm by auto-timeout.
    logic                timeout_d;

    always_comb begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
        timeout_d   = (MAX_BURSTS != 0) && (32'(burst_cnt_d) == MAX_BURSTS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            burst_cnt_q <= 8'd0;
            beep_idx_q  <= 8'd0;
            tone_cnt_q  <= '0;
            on_cnt_q    <= '0;
            off_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else if ((state_q != S_IDLE) && bus.stop) begin
            // stop outranks trigger and every timer expiry; burst_cnt_q is
            // deliberately left alone so the caller can see how far it got.
            state_q    <= S_IDLE;
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            beep_idx_q <= 8'd0;
            tone_cnt_q <= '0;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tone_cnt_q <= '0;
                    on_cnt_q   <= '0;
                    off_cnt_q  <= '0;
                    gap_cnt_q  <= '0;
                    if (bus.trigger && !bus.stop) begin
                        state_q     <= S_BEEP_ON;
                        buzzer_q    <= 1'b1;
                        active_q    <= 1'b1;
                        beep_idx_q  <= 8'd0;
                        burst_cnt_q <= 8'd0;
                    end
                end

                S_BEEP_ON: begin
                    if (on_cnt_q == ON_LAST) begin
                        // Silence lands in the same cycle the next state begins.
                        on_cnt_q   <= '0;
                        tone_cnt_q <= '0;
                        buzzer_q   <= 1'b0;
                        if (beep_idx_q < BEEP_LAST) begin
                            state_q <= S_BEEP_OFF;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        on_cnt_q <= on_cnt_q + ON_W'(1);
                        if (tone_cnt_q == TONE_LAST) begin
                            tone_cnt_q <= '0;
                            buzzer_q   <= ~buzzer_q;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + TONE_W'(1);
                        end
                    end
                end

                S_BEEP_OFF: begin
                    if (off_cnt_q == OFF_LAST) begin
                        off_cnt_q  <= '0;
                        beep_idx_q <= beep_idx_q + 8'd1;
                        state_q    <= S_BEEP_ON;
                        buzzer_q   <= 1'b1;
                        tone_cnt_q <= '0;
                    end else begin
                        off_cnt_q <= off_cnt_q + OFF_W'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q   <= '0;
                        beep_idx_q  <= 8'd0;
                        burst_cnt_q <= burst_cnt_d;
                        tone_cnt_q  <= '0;
                        if (timeout_d) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                        end else begin
                            state_q  <= S_BEEP_ON;
                            buzzer_q <= 1'b1;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    buzzer_q <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.active      = active_q;
    assign bus.burst_count = burst_cnt_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// -----------------------------------------------------------------------------
// tb_alarm_buzzer_driver
//
// Two copies of the driver share one stimulus stream: dut0 with MAX_BURSTS=2
// and dut1 with MAX_BURSTS=0 (unlimited). A reference model describes the
// expected outputs as a function of "cycles since trigger": the position in
// a burst gives the beep/tone, the burst number gives burst_count. The driver
// pushes the expected outputs for every edge; the monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_alarm_buzzer_driver;

    localparam int P_TONE  = 2;
    localparam int P_ON    = 8;
    localparam int P_OFF   = 4;
    localparam int P_BEEPS = 3;
    localparam int P_GAP   = 10;
    localparam int BL      = P_BEEPS * P_ON + (P_BEEPS - 1) * P_OFF + P_GAP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alarm_buzzer_driver_if bus0 ();
    alarm_buzzer_driver_if bus1 ();
    logic [1:0] dbg0;
    logic [1:0] dbg1;

    alarm_buzzer_driver #(
        .TONE_HALF(P_TONE), .BEEP_ON(P_ON), .BEEP_OFF(P_OFF),
        .BEEPS(P_BEEPS), .GAP(P_GAP), .MAX_BURSTS(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .dbg_state_o(dbg0)
    );

    alarm_buzzer_driver #(
        .TONE_HALF(P_TONE), .BEEP_ON(P_ON), .BEEP_OFF(P_OFF),
        .BEEPS(P_BEEPS), .GAP(P_GAP), .MAX_BURSTS(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state_o(dbg1)
    );

    // ---------------- reference model ----------------
    int  max_b [2] = '{2, 0};
    bit  run   [2];
    int  t_cyc [2];
    int  held  [2];

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Expected {buzzer, active, burst_count} t cycles into a running alarm.
    function automatic logic [9:0] model_out(input bit r, input int t, input int h);
        int p;
        int q;
        logic bz;
        if (!r) return {1'b0, 1'b0, 8'(h)};
        p  = t % BL;
        bz = 1'b0;
        for (int i = 0; i < P_BEEPS; i++) begin
            q = p - i * (P_ON + P_OFF);
            if (q >= 0 && q < P_ON) bz = ((q / P_TONE) % 2) == 0;
        end
        return {bz, 1'b1, 8'(sat255(t / BL))};
    endfunction

    task automatic model_step(input int m, input logic r, input logic tr, input logic s);
        if (!r) begin
            run[m] = 0; t_cyc[m] = 0; held[m] = 0;
        end else if (run[m] && s) begin
            held[m] = sat255(t_cyc[m] / BL);
            run[m]  = 0;
        end else if (!run[m]) begin
            if (tr && !s) begin
                run[m] = 1; t_cyc[m] = 0; held[m] = 0;
            end
        end else begin
            t_cyc[m]++;
            if (max_b[m] != 0 && t_cyc[m] >= max_b[m] * BL) begin
                run[m]  = 0;
                held[m] = max_b[m];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic tr, input logic s);
        rst_n        = r;
        bus0.trigger = tr;
        bus0.stop    = s;
        bus1.trigger = tr;
        bus1.stop    = s;
        @(posedge clk);
        model_step(0, r, tr, s);
        model_step(1, r, tr, s);
        exp_q0.push_back(model_out(run[0], t_cyc[0], held[0]));
        exp_q1.push_back(model_out(run[1], t_cyc[1], held[1]));
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic compare(input int d, input logic [9:0] e, input logic [9:0] a,
                           input logic [1:0] st);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL outputs dut%0d phase=%s: got buzzer=%b active=%b count=%0d, expected buzzer=%b active=%b count=%0d",
                     d, phase, a[9], a[8], a[7:0], e[9], e[8], e[7:0]);
        end
        n_checks++;
        if ((st != 2'd0) !== e[8]) begin
            n_errors++;
            $display("FAIL state_busy dut%0d phase=%s: got state=%0d, expected busy=%b",
                     d, phase, st, e[8]);
        end
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                compare(0, e, {bus0.buzzer, bus0.active, bus0.burst_count}, dbg0);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                compare(1, e, {bus1.buzzer, bus1.active, bus1.burst_count}, dbg1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus0.trigger = 1'b0; bus0.stop = 1'b0;
        bus1.trigger = 1'b0; bus1.stop = 1'b0;

        phase = "reset";
        repeat (3) cycle(1'b0, 1'b1, 1'b0);

        phase = "idle_stop";
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(2);

        phase = "trig_stop_same";
        cycle(1'b1, 1'b1, 1'b1);
        idle_cycles(3);

        phase = "single_trigger";
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(100);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(2);

        // Beep 2 starts 12 cycles in; its 5th cycle is t=16.
        phase = "stop_beep2";
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(16);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(5);

        phase = "retrigger_gap";
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(34);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(60);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(2);

        phase = "reset_beep_off";
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(8);
        cycle(1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(90);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(2);

        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0);
        end

        phase = "saturate";
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(10800);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(3);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d expectations left, expected 0",
                     exp_q0.size() + exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
